// File: rtl/dff.sv
// Positive-edge D flip-flop with synchronous, active-low reset.
// Width is set by WIDTH. Build wider registers by overriding WIDTH,
// not by instantiating several dff.
// Reset has priority over capture. q is driven directly from the flop.
module dff #(
  parameter int unsigned             WIDTH   = 1,
  parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next state: load RST_VAL while reset is low, otherwise take d
  always_comb begin
    q_d = d;
    if (!reset) begin
      q_d = RST_VAL;
    end
  end

  // Storage: every change to q happens on the rising edge of clk
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

`ifndef SYNTHESIS
  // Becomes set once reset has been seen low at an edge. Until then q is
  // legitimately unknown, so the behavioural checks are held off.
  logic seen_rst_q;

  // Tracks whether reset has been applied at least once
  always_ff @(posedge clk) begin
    if (!reset) begin
      seen_rst_q <= 1'b1;
    end
  end

  // An X or Z on reset at an edge is a usage error
  reset_known_a : assert property (@(posedge clk) !$isunknown(reset))
    else $error("dff: reset is unknown at a rising clk edge");

  // One edge after reset was low, q holds RST_VAL
  reset_value_a : assert property (@(posedge clk)
      (seen_rst_q === 1'b1) && ($past(reset) === 1'b0) |-> (q === RST_VAL))
    else $error("dff: q is not RST_VAL one edge after reset");

  // One edge after reset was high, q holds the d sampled at that edge
  capture_a : assert property (@(posedge clk)
      (seen_rst_q === 1'b1) && ($past(reset) === 1'b1) |-> (q === $past(d)))
    else $error("dff: q does not match d from the previous edge");
`endif

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: the default 1-bit register, an 8-bit register with
// a non-zero reset value, and a 16-bit register. All three share clk and reset.
module tb_dff;

  logic        clk;
  logic        reset;
  logic [0:0]  d1;
  logic [0:0]  q1;
  logic [7:0]  d8;
  logic [7:0]  q8;
  logic [15:0] d16;
  logic [15:0] q16;

  int checks;
  int failures;

  // Clock and reset: period 10, clk starts low
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dff u_dff1 (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  dff #(.WIDTH(8), .RST_VAL(8'hA5)) u_dff8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  dff #(.WIDTH(16)) u_dff16 (
    .clk   (clk),
    .reset (reset),
    .d     (d16),
    .q     (q16)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed stimulus and checks
  initial begin
    logic [0:0] cap_vec [4];
    logic [7:0] cap8_vec [4];
    checks   = 0;
    failures = 0;
    cap_vec  = '{1'b0, 1'b1, 1'b1, 1'b0};
    cap8_vec = '{8'h3C, 8'hFF, 8'h00, 8'h5A};

    // Reset held low for two edges with d driven high
    reset = 1'b0;
    d1    = 1'b1;
    d8    = 8'hFF;
    d16   = 16'hFFFF;
    step();
    check("rst1_e1", 16'(q1), 16'h0000);
    check("rst8_e1", 16'(q8), 16'h00A5);
    check("rst16_e1", q16, 16'h0000);
    step();
    check("rst1_e2", 16'(q1), 16'h0000);
    check("rst8_e2", 16'(q8), 16'h00A5);

    // Capture sequence, one-edge latency
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d1 = cap_vec[i];
      d8 = cap8_vec[i];
      step();
      check($sformatf("cap1_%0d", i), 16'(q1), 16'(cap_vec[i]));
      check($sformatf("cap8_%0d", i), 16'(q8), 16'(cap8_vec[i]));
    end

    // d toggles while clk is low; q must hold until the next rising edge
    d1 = 1'b1;
    step();
    check("between_pre", 16'(q1), 16'h0001);
    @(negedge clk);
    d1 = 1'b0;
    #1;
    check("between_lo0", 16'(q1), 16'h0001);
    d1 = 1'b1;
    #1;
    check("between_lo1", 16'(q1), 16'h0001);
    d1 = 1'b0;
    #1;
    check("between_lo2", 16'(q1), 16'h0001);
    step();
    check("between_edge", 16'(q1), 16'h0000);

    // Reset pulled low for exactly one edge mid-run
    d1 = 1'b1;
    d8 = 8'h11;
    step();
    check("mid_pre", 16'(q1), 16'h0001);
    reset = 1'b0;
    step();
    check("mid_rst1", 16'(q1), 16'h0000);
    check("mid_rst8", 16'(q8), 16'h00A5);
    reset = 1'b1;
    d1    = 1'b1;
    step();
    check("mid_resume1", 16'(q1), 16'h0001);
    check("mid_resume8", 16'(q8), 16'h0011);

    // Reset falls between edges: no asynchronous effect
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_lo_a", 16'(q1), 16'h0001);
    #2;
    check("async_lo_b", 16'(q1), 16'h0001);
    check("async_lo_8", 16'(q8), 16'h0011);
    step();
    check("async_edge1", 16'(q1), 16'h0000);
    check("async_edge8", 16'(q8), 16'h00A5);
    reset = 1'b1;

    // Wide register, consecutive values
    d16 = 16'hBEEF;
    step();
    check("wide_beef", q16, 16'hBEEF);
    d16 = 16'h1234;
    #2;
    check("wide_hold", q16, 16'hBEEF);
    step();
    check("wide_1234", q16, 16'h1234);
    d16 = 16'h8001;
    step();
    check("wide_8001", q16, 16'h8001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
